// File: rtl/retry_replay_pkg.sv
// Shared types for the retry/replay ingress buffer.
package retry_replay_pkg;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    IN_FLIGHT = 2'd1,
    PENDING   = 2'd2
  } entry_state_e;

  // Width of a per-entry retry counter able to hold 0..max_retries.
  function automatic int unsigned cnt_width(input int unsigned max_retries);
    if (max_retries < 2) begin
      return 1;
    end
    return $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/retry_id_fifo.sv
// FIFO of entry IDs waiting to be replayed. Every ID is present at most once,
// so a depth equal to the number of IDs can never legally overflow.
module retry_id_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth < 2) ? 1 : $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic              push_ok;
  logic              pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  // Next pointer and storage values for a push and/or pop this cycle.
  always_comb begin
    push_ok  = push_i && (!full_o || pop_i);
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pointer and storage registers, cleared to an empty FIFO on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !pop_i));
  assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/retry_replay_buffer.sv
// Ingress stage that tags each transaction with an ID, keeps a copy in an
// ID-indexed table and replays it when the downstream consumer asks for a
// retry. Entries are freed on clean completion or dropped once their retry
// budget is spent.
module retry_replay_buffer
  import retry_replay_pkg::*;
#(
  parameter type         DataType   = logic,
  parameter int unsigned IDSize     = 4,
  parameter int unsigned MaxRetries = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              fb_valid_i,
  input  logic [IDSize-1:0] fb_id_i,
  input  logic              fb_retry_i,
  output logic              drop_o,
  output logic [IDSize-1:0] drop_id_o,
  output logic              fault_o
);

  localparam int             NumIds = 2 ** IDSize;
  localparam int unsigned    CntW   = cnt_width(MaxRetries);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetries);
  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [IDSize-1:0] IdOne = {{(IDSize-1){1'b0}}, 1'b1};

  entry_state_e      state_q [NumIds];
  entry_state_e      state_d [NumIds];
  logic [CntW-1:0]   cnt_q [NumIds];
  logic [CntW-1:0]   cnt_d [NumIds];
  DataType           tbl_q [NumIds];
  DataType           tbl_d [NumIds];
  logic [IDSize-1:0] alloc_ptr_q, alloc_ptr_d;

  DataType           data_out_q, data_out_d;
  logic [IDSize-1:0] id_out_q, id_out_d;
  logic              valid_out_q, valid_out_d;
  logic              drop_q, drop_d;
  logic [IDSize-1:0] drop_id_q, drop_id_d;
  logic              fault_q, fault_d;

  logic              load;
  logic              ready;
  logic              push;
  logic              pop;
  logic [IDSize-1:0] head_id;
  logic              fifo_empty;
  logic              fifo_full;

  retry_id_fifo #(
    .Depth (NumIds),
    .Width (IDSize)
  ) u_retry_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (fb_id_i),
    .pop_i   (pop),
    .data_o  (head_id),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign load  = !valid_out_q || ready_i;
  assign ready = !rst_i && load && fifo_empty && (state_q[alloc_ptr_q] == FREE);

  assign ready_o   = ready;
  assign data_o    = data_out_q;
  assign id_o      = id_out_q;
  assign valid_o   = valid_out_q;
  assign drop_o    = drop_q;
  assign drop_id_o = drop_id_q;
  assign fault_o   = fault_q;

  // Output register source selection (replays first) and feedback handling.
  // Feedback is judged on registered state, so it never collides with the
  // entry being popped (PENDING) or allocated (FREE) in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tbl_d       = tbl_q;
    alloc_ptr_d = alloc_ptr_q;
    data_out_d  = data_out_q;
    id_out_d    = id_out_q;
    valid_out_d = valid_out_q;
    drop_d      = 1'b0;
    drop_id_d   = drop_id_q;
    fault_d     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    if (load) begin
      valid_out_d = 1'b0;
      if (!fifo_empty) begin
        pop               = 1'b1;
        data_out_d        = tbl_q[head_id];
        id_out_d          = head_id;
        valid_out_d       = 1'b1;
        state_d[head_id]  = IN_FLIGHT;
      end else if (valid_i && ready) begin
        tbl_d[alloc_ptr_q]   = data_i;
        cnt_d[alloc_ptr_q]   = '0;
        state_d[alloc_ptr_q] = IN_FLIGHT;
        data_out_d           = data_i;
        id_out_d             = alloc_ptr_q;
        valid_out_d          = 1'b1;
        alloc_ptr_d          = alloc_ptr_q + IdOne;
      end
    end

    if (fb_valid_i) begin
      if (state_q[fb_id_i] != IN_FLIGHT) begin
        fault_d = 1'b1;
      end else if (!fb_retry_i) begin
        state_d[fb_id_i] = FREE;
      end else if (cnt_q[fb_id_i] < MaxCnt) begin
        cnt_d[fb_id_i]   = cnt_q[fb_id_i] + CntOne;
        state_d[fb_id_i] = PENDING;
        push             = 1'b1;
      end else begin
        state_d[fb_id_i] = FREE;
        drop_d           = 1'b1;
        drop_id_d        = fb_id_i;
      end
    end
  end

  // Table, allocation pointer and output registers; reset discards everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        state_q[i] <= FREE;
        cnt_q[i]   <= '0;
        tbl_q[i]   <= '0;
      end
      alloc_ptr_q <= '0;
      data_out_q  <= '0;
      id_out_q    <= '0;
      valid_out_q <= 1'b0;
      drop_q      <= 1'b0;
      drop_id_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tbl_q       <= tbl_d;
      alloc_ptr_q <= alloc_ptr_d;
      data_out_q  <= data_out_d;
      id_out_q    <= id_out_d;
      valid_out_q <= valid_out_d;
      drop_q      <= drop_d;
      drop_id_q   <= drop_id_d;
      fault_q     <= fault_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full && !pop));
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && pop && (head_id == fb_id_i)));

endmodule

// File: tb/tb_retry_replay_buffer.sv
// Self-checking bench for retry_replay_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_retry_replay_buffer;

  localparam int IDSize     = 2;
  localparam int NumIds     = 4;
  localparam int MaxRetries = 2;

  localparam int S_FREE    = 0;
  localparam int S_INFLT   = 1;
  localparam int S_PENDING = 2;

  typedef logic [7:0] data_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  data_t       data_i;
  logic        valid_i;
  logic        ready_o;
  data_t       data_o;
  logic [1:0]  id_o;
  logic        valid_o;
  logic        ready_i;
  logic        fb_valid_i;
  logic [1:0]  fb_id_i;
  logic        fb_retry_i;
  logic        drop_o;
  logic [1:0]  drop_id_o;
  logic        fault_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int         m_state [NumIds];
  int         m_cnt   [NumIds];
  data_t      m_data  [NumIds];
  int         m_rq    [$];
  int         m_alloc;
  logic       m_valid;
  data_t      m_dout;
  logic [1:0] m_idout;
  logic       m_drop;
  logic [1:0] m_drop_id;
  logic       m_fault;

  retry_replay_buffer #(
    .DataType   (data_t),
    .IDSize     (IDSize),
    .MaxRetries (MaxRetries)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .id_o       (id_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .fb_valid_i (fb_valid_i),
    .fb_id_i    (fb_id_i),
    .fb_retry_i (fb_retry_i),
    .drop_o     (drop_o),
    .drop_id_o  (drop_id_o),
    .fault_o    (fault_o)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    valid_i    = 1'b0;
    data_i     = '0;
    ready_i    = 1'b1;
    fb_valid_i = 1'b0;
    fb_id_i    = '0;
    fb_retry_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic send(input data_t d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    valid_i = 1'b1;
    data_i  = 8'h5A;
    rst_i   = 1'b1;
    tick();
    tick();
    tests_run++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || id_o !== 2'd0 || drop_o !== 1'b0 ||
        drop_id_o !== 2'd0 || fault_o !== 1'b0 || ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: valid=%b data=%h id=%0d drop=%b drop_id=%0d fault=%b ready=%b, expected all zero",
               valid_o, data_o, id_o, drop_o, drop_id_o, fault_o, ready_o);
    end
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_ready: ready=%b, expected 1", ready_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_in_order();
    data_t seq [3];
    seq = '{8'hA1, 8'hB2, 8'hC3};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(seq[i]);
      tests_run++;
      if (valid_o !== 1'b1 || id_o !== i[1:0] || data_o !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL in_order[%0d]: valid=%b id=%0d data=%h, expected valid=1 id=%0d data=%h",
                 i, valid_o, id_o, data_o, i, seq[i]);
      end
    end
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fb_valid_i = 1'b1;
      fb_id_i    = i[1:0];
      fb_retry_i = 1'b0;
      tick();
      tests_run++;
      if (drop_o !== 1'b0 || fault_o !== 1'b0 || valid_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL in_order_done[%0d]: drop=%b fault=%b valid=%b, expected 0 0 0",
                 i, drop_o, fault_o, valid_o);
      end
    end
    fb_valid_i = 1'b0;
  endtask

  task automatic test_single_retry();
    do_reset();
    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    valid_i    = 1'b0;
    fb_valid_i = 1'b1;
    fb_id_i    = 2'd1;
    fb_retry_i = 1'b1;
    tick();
    fb_valid_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retry_gap: valid=%b, expected 0", valid_o);
    end
    valid_i = 1'b1;
    data_i  = 8'hD4;
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retry_blocks_input: ready=%b, expected 0", ready_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || id_o !== 2'd1 || data_o !== 8'hB2) begin
      tests_failed++;
      $display("[TB] FAIL retry_replay: valid=%b id=%0d data=%h, expected valid=1 id=1 data=b2",
               valid_o, id_o, data_o);
    end
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL retry_then_ready: ready=%b, expected 1", ready_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || id_o !== 2'd3 || data_o !== 8'hD4) begin
      tests_failed++;
      $display("[TB] FAIL retry_new_after: valid=%b id=%0d data=%h, expected valid=1 id=3 data=d4",
               valid_o, id_o, data_o);
    end
    valid_i    = 1'b0;
    fb_valid_i = 1'b1;
    fb_id_i    = 2'd1;
    fb_retry_i = 1'b0;
    tick();
    fb_valid_i = 1'b0;
    tests_run++;
    if (drop_o !== 1'b0 || fault_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retry_free: drop=%b fault=%b, expected 0 0", drop_o, fault_o);
    end
  endtask

  task automatic test_exhaustion();
    do_reset();
    send(8'hA1);
    valid_i = 1'b0;
    for (int r = 0; r <= MaxRetries; r++) begin
      fb_valid_i = 1'b1;
      fb_id_i    = 2'd0;
      fb_retry_i = 1'b1;
      tick();
      fb_valid_i = 1'b0;
      tests_run++;
      if (valid_o !== 1'b0 || fault_o !== 1'b0 || drop_o !== (r == MaxRetries) ||
          (r == MaxRetries && drop_id_o !== 2'd0)) begin
        tests_failed++;
        $display("[TB] FAIL exhaust_fb[%0d]: valid=%b fault=%b drop=%b drop_id=%0d, expected valid=0 fault=0 drop=%b drop_id=0",
                 r, valid_o, fault_o, drop_o, drop_id_o, (r == MaxRetries));
      end
      tick();
      tests_run++;
      if (r < MaxRetries) begin
        if (valid_o !== 1'b1 || id_o !== 2'd0 || data_o !== 8'hA1) begin
          tests_failed++;
          $display("[TB] FAIL exhaust_replay[%0d]: valid=%b id=%0d data=%h, expected valid=1 id=0 data=a1",
                   r, valid_o, id_o, data_o);
        end
      end else if (valid_o !== 1'b0 || drop_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL exhaust_no_replay: valid=%b drop=%b, expected 0 0", valid_o, drop_o);
      end
    end
  endtask

  task automatic test_table_full();
    do_reset();
    for (int i = 0; i < NumIds; i++) begin
      send(8'h10 + 8'(i));
      tests_run++;
      if (valid_o !== 1'b1 || id_o !== i[1:0]) begin
        tests_failed++;
        $display("[TB] FAIL full_fill[%0d]: valid=%b id=%0d, expected valid=1 id=%0d", i, valid_o, id_o, i);
      end
    end
    valid_i = 1'b1;
    data_i  = 8'hE5;
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_stall: ready=%b, expected 0", ready_o);
    end
    tick();
    fb_valid_i = 1'b1;
    fb_id_i    = 2'd2;
    fb_retry_i = 1'b0;
    #1;
    tick();
    tests_run++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_other_free: ready=%b valid=%b, expected 0 0", ready_o, valid_o);
    end
    fb_id_i = 2'd0;
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_free_same_cycle: ready=%b, expected 0", ready_o);
    end
    tick();
    fb_valid_i = 1'b0;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_free_next_cycle: ready=%b, expected 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b1 || id_o !== 2'd0 || data_o !== 8'hE5) begin
      tests_failed++;
      $display("[TB] FAIL full_wrap: valid=%b id=%0d data=%h, expected valid=1 id=0 data=e5",
               valid_o, id_o, data_o);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    send(8'hA1);
    valid_i = 1'b1;
    data_i  = 8'hB2;
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++;
      if (ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_ready[%0d]: ready=%b, expected 0", k, ready_o);
      end
      tick();
      tests_run++;
      if (valid_o !== 1'b1 || id_o !== 2'd0 || data_o !== 8'hA1) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%b id=%0d data=%h, expected valid=1 id=0 data=a1",
                 k, valid_o, id_o, data_o);
      end
    end
    ready_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release_ready: ready=%b, expected 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b1 || id_o !== 2'd1 || data_o !== 8'hB2) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: valid=%b id=%0d data=%h, expected valid=1 id=1 data=b2",
               valid_o, id_o, data_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain: valid=%b, expected 0", valid_o);
    end
  endtask

  task automatic test_fault_reset();
    data_t seq [3];
    seq = '{8'hB2, 8'hC3, 8'hD4};
    do_reset();
    send(8'hA1);
    valid_i    = 1'b0;
    fb_valid_i = 1'b1;
    fb_id_i    = 2'd3;
    fb_retry_i = 1'b0;
    tick();
    fb_valid_i = 1'b0;
    tests_run++;
    if (fault_o !== 1'b1 || drop_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fault_pulse: fault=%b drop=%b, expected 1 0", fault_o, drop_o);
    end
    tick();
    tests_run++;
    if (fault_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fault_one_cycle: fault=%b, expected 0", fault_o);
    end
    for (int i = 0; i < 3; i++) begin
      send(seq[i]);
      tests_run++;
      if (valid_o !== 1'b1 || id_o !== 2'(i + 1) || data_o !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL fault_no_change[%0d]: valid=%b id=%0d data=%h, expected valid=1 id=%0d data=%h",
                 i, valid_o, id_o, data_o, i + 1, seq[i]);
      end
    end
    data_i     = 8'hE5;
    fb_valid_i = 1'b1;
    fb_id_i    = 2'd1;
    fb_retry_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || id_o !== 2'd0 || drop_o !== 1'b0 ||
        fault_o !== 1'b0 || ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midstream_reset: valid=%b data=%h id=%0d drop=%b fault=%b ready=%b, expected all zero",
               valid_o, data_o, id_o, drop_o, fault_o, ready_o);
    end
    tick();
    rst_i      = 1'b0;
    valid_i    = 1'b0;
    fb_valid_i = 1'b0;
    tick();
    tests_run++;
    if (valid_o !== 1'b0 || drop_o !== 1'b0 || fault_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_quiet: valid=%b drop=%b fault=%b, expected 0 0 0",
               valid_o, drop_o, fault_o);
    end
    send(8'hF6);
    valid_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b1 || id_o !== 2'd0 || data_o !== 8'hF6) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_alloc: valid=%b id=%0d data=%h, expected valid=1 id=0 data=f6",
               valid_o, id_o, data_o);
    end
  endtask

  task automatic test_random();
    bit   m_load;
    bit   m_ready;
    int   fb_kind;
    int   fb;
    int   x;
    do_reset();
    for (int i = 0; i < NumIds; i++) begin
      m_state[i] = S_FREE;
      m_cnt[i]   = 0;
      m_data[i]  = '0;
    end
    m_rq.delete();
    m_alloc = 0;
    m_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      valid_i    = ($urandom_range(0, 3) != 0);
      data_i     = 8'($urandom);
      ready_i    = ($urandom_range(0, 3) != 0);
      fb_valid_i = ($urandom_range(0, 2) == 0);
      fb_id_i    = 2'($urandom_range(0, NumIds - 1));
      fb_retry_i = 1'($urandom_range(0, 1));
      #1;
      m_load  = !m_valid || ready_i;
      m_ready = m_load && (m_rq.size() == 0) && (m_state[m_alloc] == S_FREE);
      tests_run++;
      if (ready_o !== m_ready) begin
        tests_failed++;
        $display("[TB] FAIL rand_ready[%0d]: ready=%b, expected %b", c, ready_o, m_ready);
      end
      fb      = int'(fb_id_i);
      fb_kind = 0;
      if (fb_valid_i) begin
        if (m_state[fb] != S_INFLT)       fb_kind = 1;
        else if (!fb_retry_i)             fb_kind = 2;
        else if (m_cnt[fb] < MaxRetries)  fb_kind = 3;
        else                              fb_kind = 4;
      end
      if (m_load) begin
        m_valid = 1'b0;
        if (m_rq.size() > 0) begin
          x          = m_rq.pop_front();
          m_valid    = 1'b1;
          m_dout     = m_data[x];
          m_idout    = 2'(x);
          m_state[x] = S_INFLT;
        end else if (valid_i && m_ready) begin
          m_data[m_alloc]  = data_i;
          m_cnt[m_alloc]   = 0;
          m_state[m_alloc] = S_INFLT;
          m_valid          = 1'b1;
          m_dout           = data_i;
          m_idout          = 2'(m_alloc);
          m_alloc          = (m_alloc + 1) % NumIds;
        end
      end
      m_fault = (fb_kind == 1);
      m_drop  = (fb_kind == 4);
      if (fb_kind == 2 || fb_kind == 4) m_state[fb] = S_FREE;
      if (fb_kind == 4) m_drop_id = 2'(fb);
      if (fb_kind == 3) begin
        m_cnt[fb]++;
        m_state[fb] = S_PENDING;
        m_rq.push_back(fb);
      end
      tick();
      tests_run++;
      if (valid_o !== m_valid || (m_valid && (id_o !== m_idout || data_o !== m_dout))) begin
        tests_failed++;
        $display("[TB] FAIL rand_out[%0d]: valid=%b id=%0d data=%h, expected valid=%b id=%0d data=%h",
                 c, valid_o, id_o, data_o, m_valid, m_idout, m_dout);
      end
      tests_run++;
      if (drop_o !== m_drop || fault_o !== m_fault || (m_drop && drop_id_o !== m_drop_id)) begin
        tests_failed++;
        $display("[TB] FAIL rand_pulse[%0d]: drop=%b drop_id=%0d fault=%b, expected drop=%b drop_id=%0d fault=%b",
                 c, drop_o, drop_id_o, fault_o, m_drop, m_drop_id, m_fault);
      end
    end
    idle_inputs();
  endtask

  // Run every scenario in order, then report
  initial begin
    idle_inputs();
    test_reset();
    test_in_order();
    test_single_retry();
    test_exhaustion();
    test_table_full();
    test_back_pressure();
    test_fault_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
